angle_range_reducer: RTL



---
 rtl/angle_range_reducer_if.sv | 28 ++
 rtl/angle_range_reducer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/angle_range_reducer_if.sv
//------------------------------------------------------------------------------
// Module : angle_range_reducer_if
// Brief  : Valid/ready angle-in / folded-angle-out bundle for the range reducer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface angle_range_reducer_if;
    logic signed [15:0] in_angle;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] out_x;
    logic        [1:0]  out_quad;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_angle, in_valid, out_ready,
        input  in_ready, out_x, out_quad, out_valid
    );

    modport slave (
        input  in_angle, in_valid, out_ready,
        output in_ready, out_x, out_quad, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/angle_range_reducer.sv
//------------------------------------------------------------------------------
// Module : angle_range_reducer
// Brief  : Reduces a Q4.12 angle modulo 2*pi into [-pi, pi], folds it into
//          [-pi/2, pi/2] and emits it in Q2.14 with its quadrant code.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module angle_range_reducer #(
    parameter int TWO_PI_Q  = 25736,
    parameter int PI_Q      = 12868,
    parameter int HALF_PI_Q = 6434
) (
    input  wire logic            clk,
    input  wire logic            rst,
    angle_range_reducer_if.slave bus
);

    localparam logic signed [17:0] c_two_pi  = 18'(TWO_PI_Q);
    localparam logic signed [17:0] c_pi      = 18'(PI_Q);
    localparam logic signed [17:0] c_half_pi = 18'(HALF_PI_Q);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_FOLD   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic signed [17:0]        r_w;
    logic signed [15:0]        r_out_x;
    logic        [1:0]         r_out_quad;
    logic                      r_out_valid;
    logic signed [17:0]        w_fold;
    logic        [1:0]         w_quad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_state_next = S_REDUCE;
                end
            end
            S_REDUCE: begin
                if (!(r_w > c_pi) && !(r_w < -c_pi)) begin
                    w_state_next = S_FOLD;
                end
            end
            S_FOLD: begin
                w_state_next = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Folding uses sin(pi-x) = sin(x) and sin(-pi-x) = sin(x); +/-pi/2 stay put.
    always_comb begin
        w_fold = r_w;
        w_quad = 2'd0;
        if (r_w > c_half_pi) begin
            w_fold = c_pi - r_w;
            w_quad = 2'd1;
        end else if (r_w < -c_half_pi) begin
            w_fold = -c_pi - r_w;
            w_quad = 2'd2;
        end else if (r_w < 18'sd0) begin
            w_quad = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w         <= '0;
            r_out_x     <= '0;
            r_out_quad  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_w <= {{2{bus.in_angle[15]}}, bus.in_angle};
                    end
                end
                S_REDUCE: begin
                    if (r_w > c_pi) begin
                        r_w <= r_w - c_two_pi;
                    end else if (r_w < -c_pi) begin
                        r_w <= r_w + c_two_pi;
                    end
                end
                S_FOLD: begin
                    // |fold| <= pi/2, so the Q4.12 -> Q2.14 shift cannot overflow.
                    r_out_x     <= {w_fold[13:0], 2'b00};
                    r_out_quad  <= w_quad;
                    r_out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_x     = r_out_x;
    assign bus.out_quad  = r_out_quad;
    assign bus.out_valid = r_out_valid;

endmodule

`default_nettype wire
